// File: rtl/vrc4_pkg.sv
// Shared constants and types for the VRC4 mapper-21 CPU write decoder and bank register file.
// Register groups are cpu_addr[14:12]. The SST map places the CHR banks at 4..19.
package vrc4_pkg;

  localparam logic [2:0] REG_PRG0  = 3'd0;
  localparam logic [2:0] REG_MISC  = 3'd1;
  localparam logic [2:0] REG_PRG1  = 3'd2;
  localparam logic [2:0] REG_CHR01 = 3'd3;
  localparam logic [2:0] REG_CHR23 = 3'd4;
  localparam logic [2:0] REG_CHR45 = 3'd5;
  localparam logic [2:0] REG_CHR67 = 3'd6;
  localparam logic [2:0] REG_IRQ   = 3'd7;

  localparam int ADDR_MODE_OR   = 0;  // lo = A1|A6, hi = A2|A7
  localparam int ADDR_MODE_A1A2 = 1;
  localparam int ADDR_MODE_A6A7 = 2;

  typedef enum logic [1:0] {
    MIR_VERT  = 2'd0,
    MIR_HORZ  = 2'd1,
    MIR_SCR_A = 2'd2,
    MIR_SCR_B = 2'd3
  } mirror_e;

  localparam logic [7:0] SST_PRG0     = 8'd0;
  localparam logic [7:0] SST_PRG1     = 8'd1;
  localparam logic [7:0] SST_MISC     = 8'd2;
  localparam logic [7:0] SST_CHR_BASE = 8'd4;
  localparam logic [7:0] SST_CHR_LAST = 8'd19;

  typedef struct packed {
    logic       act;
    logic       we_reg;
    logic [7:0] addr;
    logic [7:0] dato;
  } sst_bus_t;

endpackage

// File: rtl/vrc4_addr_sel.sv
// Maps the board's address-line wiring onto the register-select {hi, lo} pair.
// This module is shared with the VRC2 variant, which uses different wiring.
module vrc4_addr_sel
  import vrc4_pkg::*;
#(
  parameter int ADDR_MODE = ADDR_MODE_OR
) (
  input  logic i_a1,
  input  logic i_a2,
  input  logic i_a6,
  input  logic i_a7,
  output logic o_hi,
  output logic o_lo
);

  always_comb begin
    o_hi = i_a2 | i_a7;
    o_lo = i_a1 | i_a6;
    case (ADDR_MODE)
      ADDR_MODE_A1A2: begin
        o_hi = i_a2;
        o_lo = i_a1;
      end
      ADDR_MODE_A6A7: begin
        o_hi = i_a7;
        o_lo = i_a6;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vrc4_reg_file.sv
// Handles VRC4 writes to $8000-$FFFF. Holds the PRG, CHR and mirror/WRAM registers,
// drives the bank outputs and the IRQ strobes, and supports save-state access.
module vrc4_reg_file
  import vrc4_pkg::*;
#(
  parameter int ADDR_MODE = ADDR_MODE_OR
) (
  input  logic        cpu_m2,
  input  logic        map_rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_rw,
  input  logic [13:0] ppu_addr,
  output logic [4:0]  prg_bank,
  output logic [8:0]  chr_bank,
  output logic [1:0]  mirror,
  output logic        wram_en,
  output logic        ce_latl,
  output logic        ce_lath,
  output logic        ce_ctrl,
  output logic        ce_ackn,
  output logic        ce_latx,
  input  sst_bus_t    sst,
  output logic [7:0]  sst_di
);

  logic       w_hi, w_lo, w_wr, w_irq, w_sst_chr;
  logic [2:0] w_grp, w_grp_m3, w_chr_n, w_sst_idx;
  logic [7:0] w_sst_off;
  logic       w_unused;

  logic [4:0] r_prg0, r_prg1;
  logic       r_prg_mode, r_wram_en;
  logic [1:0] r_mirror;
  logic [8:0] r_chr [8];

  vrc4_addr_sel #(.ADDR_MODE(ADDR_MODE)) u_addr_sel (
    .i_a1 (cpu_addr[1]),
    .i_a2 (cpu_addr[2]),
    .i_a6 (cpu_addr[6]),
    .i_a7 (cpu_addr[7]),
    .o_hi (w_hi),
    .o_lo (w_lo)
  );

  assign w_wr      = !cpu_rw && cpu_addr[15];
  assign w_grp     = cpu_addr[14:12];
  assign w_grp_m3  = w_grp - REG_CHR01;
  assign w_chr_n   = {w_grp_m3[1:0], w_hi};
  assign w_sst_off = sst.addr - SST_CHR_BASE;
  assign w_sst_chr = (sst.addr >= SST_CHR_BASE) && (sst.addr <= SST_CHR_LAST);
  assign w_sst_idx = w_sst_off[3:1];

  always_ff @(negedge cpu_m2 or posedge map_rst) begin
    if (map_rst) begin
      r_prg0     <= '0;
      r_prg1     <= '0;
      r_prg_mode <= 1'b0;
      r_wram_en  <= 1'b0;
      r_mirror   <= MIR_VERT;
      for (int i = 0; i < 8; i++) r_chr[i] <= '0;
    end else if (sst.act) begin
      // Save-state access owns the registers and blocks CPU writes.
      if (sst.we_reg) begin
        if (w_sst_chr) begin
          if (sst.addr[0]) r_chr[w_sst_idx][8]   <= sst.dato[0];
          else             r_chr[w_sst_idx][7:0] <= sst.dato;
        end else begin
          case (sst.addr)
            SST_PRG0: r_prg0 <= sst.dato[4:0];
            SST_PRG1: r_prg1 <= sst.dato[4:0];
            SST_MISC: {r_prg_mode, r_wram_en, r_mirror} <= sst.dato[3:0];
            default: ;
          endcase
        end
      end
    end else if (w_wr) begin
      case (w_grp)
        REG_PRG0: r_prg0 <= cpu_data[4:0];
        REG_MISC: begin
          if (!w_hi) begin
            r_mirror <= cpu_data[1:0];
          end else if (!w_lo) begin
            r_wram_en  <= cpu_data[0];
            r_prg_mode <= cpu_data[1];
          end
        end
        REG_PRG1: r_prg1 <= cpu_data[4:0];
        REG_CHR01, REG_CHR23, REG_CHR45, REG_CHR67: begin
          if (w_lo) r_chr[w_chr_n][8:4] <= cpu_data[4:0];
          else      r_chr[w_chr_n][3:0] <= cpu_data[3:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (cpu_addr[14:13])
      2'd0:    prg_bank = r_prg_mode ? 5'h1E : r_prg0;
      2'd1:    prg_bank = r_prg1;
      2'd2:    prg_bank = r_prg_mode ? r_prg0 : 5'h1E;
      default: prg_bank = 5'h1F;
    endcase
  end

  assign chr_bank = r_chr[ppu_addr[12:10]];
  assign mirror   = r_mirror;
  assign wram_en  = r_wram_en;

  assign w_irq   = w_wr && (w_grp == REG_IRQ);
  assign ce_latl = w_irq && !w_hi && !w_lo;
  assign ce_lath = w_irq && !w_hi &&  w_lo;
  assign ce_ctrl = w_irq &&  w_hi && !w_lo;
  assign ce_ackn = w_irq &&  w_hi &&  w_lo;
  assign ce_latx = 1'b0;

  always_comb begin
    sst_di = 8'hFF;
    if (w_sst_chr) begin
      sst_di = sst.addr[0] ? {7'b0, r_chr[w_sst_idx][8]} : r_chr[w_sst_idx][7:0];
    end else begin
      case (sst.addr)
        SST_PRG0: sst_di = {3'b0, r_prg0};
        SST_PRG1: sst_di = {3'b0, r_prg1};
        SST_MISC: sst_di = {4'b0, r_prg_mode, r_wram_en, r_mirror};
        default: ;
      endcase
    end
  end

  assign w_unused = ^{cpu_addr[11:8], cpu_addr[5:3], cpu_addr[0], cpu_data[7:5],
                      ppu_addr[13], ppu_addr[9:0], w_sst_off[7:4], w_sst_off[0], w_grp_m3[2]};

endmodule

// File: tb/tb_vrc4_reg_file.sv
// Scoreboard bench: one instance per ADDR_MODE shares every input. Each is compared
// against a behavioural model of the register map on every cycle.
module tb_vrc4_reg_file;
  import vrc4_pkg::*;

  logic        cpu_m2 = 1'b1;
  logic        map_rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_data = 8'h0;
  logic        cpu_rw = 1'b1;
  logic [13:0] ppu_addr = 14'h0;
  sst_bus_t    sst = '0;

  logic [4:0] prg_bank [3];
  logic [8:0] chr_bank [3];
  logic [1:0] mirror   [3];
  logic [7:0] sst_di   [3];
  logic       wram_en [3], ce_latl [3], ce_lath [3], ce_ctrl [3], ce_ackn [3], ce_latx [3];

  always #5 cpu_m2 = ~cpu_m2;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vrc4_reg_file #(.ADDR_MODE(g)) dut (
      .cpu_m2   (cpu_m2),
      .map_rst  (map_rst),
      .cpu_addr (cpu_addr),
      .cpu_data (cpu_data),
      .cpu_rw   (cpu_rw),
      .ppu_addr (ppu_addr),
      .prg_bank (prg_bank[g]),
      .chr_bank (chr_bank[g]),
      .mirror   (mirror[g]),
      .wram_en  (wram_en[g]),
      .ce_latl  (ce_latl[g]),
      .ce_lath  (ce_lath[g]),
      .ce_ctrl  (ce_ctrl[g]),
      .ce_ackn  (ce_ackn[g]),
      .ce_latx  (ce_latx[g]),
      .sst      (sst),
      .sst_di   (sst_di[g])
    );
  end

  // Reference model, one register set per address wiring
  logic [4:0] m_prg0 [3], m_prg1 [3];
  logic       m_pmode [3], m_wram [3];
  logic [1:0] m_mir [3];
  logic [8:0] m_chr [3][8];

  typedef struct {
    int          dut;
    int          fld;
    logic [15:0] exp;
  } chk_t;
  chk_t sb_q [$];

  string fnames [6] = '{"prg_bank", "chr_bank", "mirror", "wram_en", "strobes", "sst_di"};
  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [1:0] hilo(input int mode, input logic [15:0] a);
    if (mode == 0)      return {a[2] | a[7], a[1] | a[6]};
    else if (mode == 1) return {a[2], a[1]};
    else                return {a[7], a[6]};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_prg0[m] = '0; m_prg1[m] = '0; m_pmode[m] = 1'b0; m_wram[m] = 1'b0; m_mir[m] = '0;
      for (int i = 0; i < 8; i++) m_chr[m][i] = '0;
    end
  endtask

  task automatic model_write();
    for (int m = 0; m < 3; m++) begin
      int sa, nib, n;
      logic [1:0] hl;
      sa  = int'(sst.addr);
      nib = int'(cpu_addr[15:12]);
      hl  = hilo(m, cpu_addr);
      if (sst.act) begin
        if (sst.we_reg) begin
          if (sa == 0) m_prg0[m] = sst.dato[4:0];
          else if (sa == 1) m_prg1[m] = sst.dato[4:0];
          else if (sa == 2) begin
            m_pmode[m] = sst.dato[3]; m_wram[m] = sst.dato[2]; m_mir[m] = sst.dato[1:0];
          end else if (sa >= 4 && sa <= 19) begin
            if (sa % 2 == 1) m_chr[m][(sa - 4) / 2][8]   = sst.dato[0];
            else             m_chr[m][(sa - 4) / 2][7:0] = sst.dato;
          end
        end
      end else if (!cpu_rw && cpu_addr[15]) begin
        if (nib == 8) m_prg0[m] = cpu_data[4:0];
        else if (nib == 9) begin
          if (!hl[1]) m_mir[m] = cpu_data[1:0];
          else if (!hl[0]) begin m_wram[m] = cpu_data[0]; m_pmode[m] = cpu_data[1]; end
        end else if (nib == 10) m_prg1[m] = cpu_data[4:0];
        else if (nib >= 11 && nib <= 14) begin
          n = 2 * (nib - 11) + int'(hl[1]);
          if (hl[0]) m_chr[m][n][8:4] = cpu_data[4:0];
          else       m_chr[m][n][3:0] = cpu_data[3:0];
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_prg(input int m);
    case (cpu_addr[14:13])
      2'd0:    return m_pmode[m] ? 16'h1E : {11'b0, m_prg0[m]};
      2'd1:    return {11'b0, m_prg1[m]};
      2'd2:    return m_pmode[m] ? {11'b0, m_prg0[m]} : 16'h1E;
      default: return 16'h1F;
    endcase
  endfunction

  function automatic logic [15:0] exp_strobe(input int m);
    if (!cpu_rw && cpu_addr[15:12] == 4'hF) return 16'd1 << hilo(m, cpu_addr);
    return 16'd0;
  endfunction

  function automatic logic [15:0] exp_sst(input int m);
    int sa;
    sa = int'(sst.addr);
    if (sa == 0) return {11'b0, m_prg0[m]};
    if (sa == 1) return {11'b0, m_prg1[m]};
    if (sa == 2) return {12'b0, m_pmode[m], m_wram[m], m_mir[m]};
    if (sa >= 4 && sa <= 19) begin
      if (sa % 2 == 1) return {15'b0, m_chr[m][(sa - 4) / 2][8]};
      return {8'b0, m_chr[m][(sa - 4) / 2][7:0]};
    end
    return 16'h00FF;
  endfunction

  function automatic logic [15:0] act_val(input int d, input int f);
    case (f)
      0:       return {11'b0, prg_bank[d]};
      1:       return {7'b0, chr_bank[d]};
      2:       return {14'b0, mirror[d]};
      3:       return {15'b0, wram_en[d]};
      4:       return {11'b0, ce_latx[d], ce_ackn[d], ce_ctrl[d], ce_lath[d], ce_latl[d]};
      default: return {8'b0, sst_di[d]};
    endcase
  endfunction

  task automatic push_expected();
    for (int m = 0; m < 3; m++) begin
      sb_q.push_back('{m, 0, exp_prg(m)});
      sb_q.push_back('{m, 1, {7'b0, m_chr[m][ppu_addr[12:10]]}});
      sb_q.push_back('{m, 2, {14'b0, m_mir[m]}});
      sb_q.push_back('{m, 3, {15'b0, m_wram[m]}});
      sb_q.push_back('{m, 4, exp_strobe(m)});
      sb_q.push_back('{m, 5, exp_sst(m)});
    end
  endtask

  // Inputs change on the rising edge and the registers update on the falling edge.
  task automatic cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                       input logic [13:0] p, input logic act, input logic we,
                       input logic [7:0] sa, input logic [7:0] sd, input logic rst);
    @(posedge cpu_m2);
    map_rst = 1'b0;
    cpu_addr = a; cpu_data = d; cpu_rw = rw; ppu_addr = p;
    sst.act = act; sst.we_reg = we; sst.addr = sa; sst.dato = sd;
    if (rst) begin
      #1;
      map_rst = 1'b1;
      model_reset();
    end
    push_expected();
    if (!rst) model_write();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cycle(a, d, 1'b0, 14'h0, 1'b0, 1'b0, 8'd3, 8'h0, 1'b0);
  endtask

  task automatic rd(input logic [15:0] a, input logic [13:0] p);
    cycle(a, 8'h00, 1'b1, p, 1'b0, 1'b0, 8'd0, 8'h0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge cpu_m2);
      #2;
      while (sb_q.size() > 0) begin
        chk_t c;
        logic [15:0] got;
        c = sb_q.pop_front();
        got = act_val(c.dut, c.fld);
        n_checks++;
        if (got !== c.exp) begin
          n_errors++;
          $display("FAIL %s mode%0d addr=%h ppu=%h: got %h expected %h",
                   fnames[c.fld], c.dut, cpu_addr, ppu_addr, got, c.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2, r3;
    model_reset();
    rd(16'h8000, 14'h0000);
    rd(16'hA000, 14'h0400);
    rd(16'hC000, 14'h1000);
    rd(16'hE000, 14'h1C00);

    wr(16'h8000, 8'h05);
    wr(16'hA000, 8'h07);
    wr(16'h9004, 8'h02);
    rd(16'h8000, 14'h0000);
    rd(16'hA000, 14'h0000);
    rd(16'hC000, 14'h0000);
    rd(16'hE000, 14'h0000);

    wr(16'hD000, 8'h0A);
    wr(16'hD002, 8'h13);
    rd(16'h8000, 14'h1000);
    wr(16'hD000, 8'h0A);
    wr(16'hD040, 8'h13);
    rd(16'h8000, 14'h1000);

    wr(16'hF000, 8'h00);
    wr(16'hF002, 8'h00);
    wr(16'hF004, 8'h00);
    wr(16'hF006, 8'h00);
    rd(16'hF004, 14'h0000);

    cycle(16'hB002, 8'h55, 1'b0, 14'h0000, 1'b1, 1'b1, 8'd5, 8'h01, 1'b0);
    cycle(16'h8000, 8'h00, 1'b1, 14'h0000, 1'b1, 1'b0, 8'd5, 8'h00, 1'b0);
    cycle(16'h8000, 8'h00, 1'b1, 14'h0000, 1'b1, 1'b0, 8'd30, 8'h00, 1'b0);
    rd(16'hB000, 14'h0000);

    for (int k = 0; k < 400; k++) begin
      logic [15:0] a;
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      a = r1[15:0];
      if (r1[17:16] != 2'b00) a[15] = 1'b1;
      cycle(a, r2[7:0], r1[19:18] == 2'b00, r2[21:8], r1[23:20] == 4'h0, r1[24],
            {3'b0, r3[4:0]}, r3[15:8], 1'b0);
    end

    cycle(16'h8000, 8'h00, 1'b1, 14'h1400, 1'b0, 1'b0, 8'd2, 8'h00, 1'b1);
    rd(16'hA000, 14'h0800);
    rd(16'hC000, 14'h1C00);
    rd(16'hE000, 14'h0000);

    #5;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
